// File: rtl/ag_channel_controller_pkg.sv
// Shared types for the channel controller: per-channel state encoding,
// polarity meanings and a small constant helper.
package ag_ctrl_pkg;

   typedef enum logic [1:0] {
      OFF   = 2'd0,
      ON    = 2'd1,
      FAULT = 2'd2
   } ch_state_t;

   localparam logic RAISE = 1'b0;
   localparam logic LOWER = 1'b1;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/ag_channel_controller_if.sv
// Sensor/threshold/control bundle between the controller and whoever drives it.
interface ag_channel_controller_if #(
   parameter int N_CH = 4,
   parameter int SW   = 4
);
   logic                 ena;
   logic [N_CH*SW-1:0]   sensor;
   logic [N_CH*SW-1:0]   thr_lo;
   logic [N_CH*SW-1:0]   thr_hi;
   logic [N_CH-1:0]      polarity;
   logic                 override;
   logic                 fault_clr;
   logic [N_CH-1:0]      act;
   logic [N_CH-1:0]      fault;
   logic [N_CH-1:0]      cfg_err;
   logic                 fault_any;
   logic                 heartbeat;

   modport master (
      output ena, sensor, thr_lo, thr_hi, polarity, override, fault_clr,
      input  act, fault, cfg_err, fault_any, heartbeat
   );

   modport slave (
      input  ena, sensor, thr_lo, thr_hi, polarity, override, fault_clr,
      output act, fault, cfg_err, fault_any, heartbeat
   );
endinterface

// File: rtl/ag_channel_fsm.sv
// One channel: hysteresis demand register, dwell counter and OFF/ON/FAULT
// state machine. The actuator drive is a decode of the state register.
module ag_channel_fsm
   import ag_ctrl_pkg::*;
#(
   parameter int SW      = 4,
   parameter int MIN_ON  = 1000,
   parameter int MIN_OFF = 1000,
   parameter int MAX_ON  = 1_000_000
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_ena,
   input  logic [SW-1:0] i_sensor,
   input  logic [SW-1:0] i_thr_lo,
   input  logic [SW-1:0] i_thr_hi,
   input  logic          i_polarity,
   input  logic          i_override,
   input  logic          i_fault_clr,
   output logic          o_act,
   output logic          o_fault,
   output logic          o_cfg_err,
   output logic          o_flag_next
);

   localparam int DMAX = max3(MIN_ON, MIN_OFF, MAX_ON);
   localparam int DW   = $clog2(DMAX) + 1;
   localparam logic [DW-1:0] D_SAT = DW'(DMAX);
   localparam logic [DW-1:0] D_OFF = DW'(MIN_OFF - 1);
   localparam logic [DW-1:0] D_ON  = DW'(MIN_ON - 1);
   localparam logic [DW-1:0] D_MAX = DW'(MAX_ON - 1);

   ch_state_t     r_state, w_state_next;
   logic [DW-1:0] r_dwell, w_dwell_next;
   logic          r_demand, w_demand_next;
   logic          r_cfg_err, w_cfg_err_next;
   logic          r_fault, w_fault_next;

   // Inverted thresholds make the band meaningless, so demand is suppressed.
   always_comb begin
      w_cfg_err_next = (i_thr_lo > i_thr_hi);
      w_demand_next  = r_demand;
      if (w_cfg_err_next) begin
         w_demand_next = 1'b0;
      end else if (i_polarity == RAISE) begin
         if (i_sensor < i_thr_lo)      w_demand_next = 1'b1;
         else if (i_sensor > i_thr_hi) w_demand_next = 1'b0;
      end else begin
         if (i_sensor > i_thr_hi)      w_demand_next = 1'b1;
         else if (i_sensor < i_thr_lo) w_demand_next = 1'b0;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_fault_next = r_fault;
      case (r_state)
         OFF: begin
            if (r_demand && (r_dwell >= D_OFF) && !i_override && !r_cfg_err)
               w_state_next = ON;
         end
         ON: begin
            // Override wins over the stuck-on limit when both land together.
            if (i_override || (!r_demand && (r_dwell >= D_ON))) begin
               w_state_next = OFF;
            end else if (r_dwell == D_MAX) begin
               w_state_next = FAULT;
               w_fault_next = 1'b1;
            end
         end
         FAULT: begin
            if (i_fault_clr) begin
               w_state_next = OFF;
               w_fault_next = 1'b0;
            end
         end
         default: begin
            w_state_next = OFF;
            w_fault_next = 1'b0;
         end
      endcase

      if (w_state_next != r_state)
         w_dwell_next = '0;
      else if (r_dwell == D_SAT)
         w_dwell_next = r_dwell;
      else
         w_dwell_next = r_dwell + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= OFF;
         r_dwell   <= '0;
         r_demand  <= 1'b0;
         r_cfg_err <= 1'b0;
         r_fault   <= 1'b0;
      end else if (i_ena) begin
         r_state   <= w_state_next;
         r_dwell   <= w_dwell_next;
         r_demand  <= w_demand_next;
         r_cfg_err <= w_cfg_err_next;
         r_fault   <= w_fault_next;
      end
   end

   assign o_act       = (r_state == ON);
   assign o_fault     = r_fault;
   assign o_cfg_err   = r_cfg_err;
   assign o_flag_next = w_fault_next | w_cfg_err_next;

endmodule

// File: rtl/ag_channel_controller.sv
// Multi-channel hysteresis actuator controller: one FSM per channel plus a
// shared heartbeat and a registered summary fault flag.
module ag_channel_controller
   import ag_ctrl_pkg::*;
#(
   parameter int N_CH    = 4,
   parameter int SW      = 4,
   parameter int MIN_ON  = 1000,
   parameter int MIN_OFF = 1000,
   parameter int MAX_ON  = 1_000_000,
   parameter int HB_DIV  = 12_500_000
) (
   input  logic                    clk,
   input  logic                    rst,
   ag_channel_controller_if.slave  ctrl
);

   localparam int HBW = $clog2(HB_DIV);
   localparam logic [HBW-1:0] HB_LAST = HBW'(HB_DIV - 1);

   logic [N_CH-1:0] w_act;
   logic [N_CH-1:0] w_fault;
   logic [N_CH-1:0] w_cfg_err;
   logic [N_CH-1:0] w_flag_next;
   logic [HBW-1:0]  r_hb_cnt;
   logic            r_heartbeat;
   logic            r_fault_any;

   genvar gi;
   generate
      for (gi = 0; gi < N_CH; gi++) begin : g_ch
         ag_channel_fsm #(
            .SW      (SW),
            .MIN_ON  (MIN_ON),
            .MIN_OFF (MIN_OFF),
            .MAX_ON  (MAX_ON)
         ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .i_ena       (ctrl.ena),
            .i_sensor    (ctrl.sensor[gi*SW +: SW]),
            .i_thr_lo    (ctrl.thr_lo[gi*SW +: SW]),
            .i_thr_hi    (ctrl.thr_hi[gi*SW +: SW]),
            .i_polarity  (ctrl.polarity[gi]),
            .i_override  (ctrl.override),
            .i_fault_clr (ctrl.fault_clr),
            .o_act       (w_act[gi]),
            .o_fault     (w_fault[gi]),
            .o_cfg_err   (w_cfg_err[gi]),
            .o_flag_next (w_flag_next[gi])
         );
      end
   endgenerate

   // fault_any is built from the channels' next values so it lines up with them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hb_cnt    <= '0;
         r_heartbeat <= 1'b0;
         r_fault_any <= 1'b0;
      end else if (ctrl.ena) begin
         r_fault_any <= |w_flag_next;
         if (r_hb_cnt == HB_LAST) begin
            r_hb_cnt    <= '0;
            r_heartbeat <= ~r_heartbeat;
         end else begin
            r_hb_cnt <= r_hb_cnt + 1'b1;
         end
      end
   end

   assign ctrl.act       = w_act;
   assign ctrl.fault     = w_fault;
   assign ctrl.cfg_err   = w_cfg_err;
   assign ctrl.fault_any = r_fault_any;
   assign ctrl.heartbeat = r_heartbeat;

endmodule

// File: tb/tb_ag_channel_controller.sv
// Scoreboard bench: a cycle-level behavioural model predicts the outputs after
// every clock edge; a monitor compares them against the controller.
module tb_ag_channel_controller;

   localparam int N_CH    = 4;
   localparam int SW      = 4;
   localparam int MIN_ON  = 4;
   localparam int MIN_OFF = 4;
   localparam int MAX_ON  = 16;
   localparam int HB_DIV  = 8;
   localparam int EW      = 3*N_CH + 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ag_channel_controller_if #(.N_CH(N_CH), .SW(SW)) bus ();

   ag_channel_controller #(
      .N_CH(N_CH), .SW(SW), .MIN_ON(MIN_ON), .MIN_OFF(MIN_OFF),
      .MAX_ON(MAX_ON), .HB_DIV(HB_DIV)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .ctrl (bus)
   );

   // Reference model: mode 0 = off, 1 = on, 2 = faulted.
   int        m_mode [N_CH];
   int        m_time [N_CH];
   bit        m_dem  [N_CH];
   bit        m_cfg  [N_CH];
   int        m_hb_n;
   bit        m_hb;
   logic [EW-1:0] q[$];
   int        total = 0;
   int        bad   = 0;
   bit        done  = 0;

   task automatic chk(input string nm, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, want);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N_CH; i++) begin
         m_mode[i] = 0; m_time[i] = 0; m_dem[i] = 0; m_cfg[i] = 0;
      end
      m_hb_n = 0;
      m_hb   = 0;
   endtask

   function automatic logic [EW-1:0] model_out();
      logic [N_CH-1:0] a, f, c;
      for (int i = 0; i < N_CH; i++) begin
         a[i] = (m_mode[i] == 1);
         f[i] = (m_mode[i] == 2);
         c[i] = m_cfg[i];
      end
      return {a, f, c, (|f) | (|c), m_hb};
   endfunction

   // Predict the state after the coming edge from the inputs now on the bus.
   task automatic step_push();
      int s, lo, hi, nm;
      bit bad_cfg;
      if (rst) begin
         model_reset();
      end else if (bus.ena) begin
         for (int i = 0; i < N_CH; i++) begin
            s  = int'(bus.sensor[i*SW +: SW]);
            lo = int'(bus.thr_lo[i*SW +: SW]);
            hi = int'(bus.thr_hi[i*SW +: SW]);
            bad_cfg = (lo > hi);
            nm = m_mode[i];
            if (m_mode[i] == 0) begin
               if (m_dem[i] && m_time[i] + 1 >= MIN_OFF && !bus.override && !m_cfg[i]) nm = 1;
            end else if (m_mode[i] == 1) begin
               if (bus.override || (!m_dem[i] && m_time[i] + 1 >= MIN_ON)) nm = 0;
               else if (m_time[i] + 1 == MAX_ON) nm = 2;
            end else if (bus.fault_clr) begin
               nm = 0;
            end
            m_time[i] = (nm != m_mode[i]) ? 0 : m_time[i] + 1;
            m_mode[i] = nm;
            if (bad_cfg)                     m_dem[i] = 0;
            else if (bus.polarity[i] == 1'b0) begin
               if (s < lo) m_dem[i] = 1; else if (s > hi) m_dem[i] = 0;
            end else begin
               if (s > hi) m_dem[i] = 1; else if (s < lo) m_dem[i] = 0;
            end
            m_cfg[i] = bad_cfg;
         end
         m_hb_n++;
         if (m_hb_n == HB_DIV) begin
            m_hb_n = 0;
            m_hb   = !m_hb;
         end
      end
      q.push_back(model_out());
   endtask

   task automatic cyc();
      step_push();
      @(negedge clk);
   endtask

   task automatic set_ch(input int i, input int s, input int lo, input int hi, input bit p);
      bus.sensor[i*SW +: SW] = SW'(s);
      bus.thr_lo[i*SW +: SW] = SW'(lo);
      bus.thr_hi[i*SW +: SW] = SW'(hi);
      bus.polarity[i]        = p;
   endtask

   task automatic set_s(input int i, input int s);
      bus.sensor[i*SW +: SW] = SW'(s);
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      model_reset();
      #1;
      chk("async_reset_outputs", int'({bus.act, bus.fault, bus.cfg_err, bus.fault_any, bus.heartbeat}), 0);
      repeat (n) cyc();
      rst = 1'b0;
   endtask

   initial begin
      model_reset();
      bus.ena = 1'b1; bus.override = 1'b0; bus.fault_clr = 1'b0;
      bus.sensor = '0; bus.thr_lo = '0; bus.thr_hi = '0; bus.polarity = '0;
      for (int i = 0; i < N_CH; i++) set_ch(i, 7, 5, 10, 1'b0);
      fork
         begin : stim
            int rise, fall, cnt;
            set_s(0, 3);
            @(negedge clk);
            do_reset(2);
            // ch0 demand comes on at the first edge, MIN_OFF dwell gates act
            rise = 0;
            for (int k = 1; k <= 10; k++) begin
               cyc();
               if (bus.act[0] && rise == 0) rise = k;
            end
            chk("act0_rise_cycle", rise, 4);
            set_s(0, 7);  repeat (6) cyc();
            set_s(0, 12); repeat (6) cyc();
            // ch2 cooler: brief excursion above hi latches demand
            set_ch(2, 12, 5, 10, 1'b1); repeat (2) cyc();
            set_s(2, 7); repeat (8) cyc();
            set_s(2, 2); repeat (6) cyc();
            // ch1 stuck on -> fault, then clear
            set_s(1, 3); repeat (25) cyc();
            bus.fault_clr = 1'b1; cyc(); bus.fault_clr = 1'b0;
            repeat (8) cyc();
            set_s(1, 12); repeat (6) cyc();
            // ch3 inverted thresholds
            set_ch(3, 3, 9, 4, 1'b0); repeat (6) cyc();
            set_ch(3, 7, 5, 10, 1'b0); repeat (2) cyc();
            // everything on, then override and freeze
            set_s(0, 3); set_s(1, 3); set_s(2, 12); set_s(3, 3);
            repeat (8) cyc();
            bus.override = 1'b1; cyc(); bus.override = 1'b0;
            bus.ena = 1'b0; repeat (10) cyc(); bus.ena = 1'b1;
            repeat (8) cyc();
            do_reset(1);
            rise = 0; fall = 0;
            for (int k = 1; k <= 18; k++) begin
               cyc();
               if (bus.heartbeat && rise == 0) rise = k;
               if (!bus.heartbeat && rise != 0 && fall == 0) fall = k;
            end
            chk("hb_first_rise", rise, HB_DIV);
            chk("hb_first_fall", fall, 2*HB_DIV);
            // randomized phase
            cnt = 0;
            repeat (1500) begin
               cnt++;
               if ($urandom_range(0, 9) == 0) set_s($urandom_range(0, N_CH-1), $urandom_range(0, 15));
               if ($urandom_range(0, 199) == 0)
                  set_ch($urandom_range(0, N_CH-1), $urandom_range(0, 15),
                         $urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom_range(0, 1)));
               bus.override  = ($urandom_range(0, 29) == 0);
               bus.fault_clr = ($urandom_range(0, 19) == 0);
               bus.ena       = ($urandom_range(0, 9) != 0);
               if ($urandom_range(0, 499) == 0) do_reset(1);
               else cyc();
            end
            bus.override = 1'b0; bus.fault_clr = 1'b0; bus.ena = 1'b1;
            done = 1;
         end
         begin : mon
            logic [EW-1:0] e, g;
            int idle;
            idle = 0;
            while (!done || q.size() > 0) begin
               @(posedge clk);
               #1;
               if (q.size() > 0) begin
                  e = q.pop_front();
                  g = {bus.act, bus.fault, bus.cfg_err, bus.fault_any, bus.heartbeat};
                  chk("act_fault_cfg_any_hb", int'(g), int'(e));
                  idle = 0;
               end else if (done) begin
                  idle++;
                  if (idle > 4) break;
               end
            end
         end
      join
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ag_channel_controller.md
AG_CHANNEL_CONTROLLER -- requirements
Module: ag_channel_controller

Interface
REQ-001 Parameter N_CH, default 4: number of independent sensor/actuator channels, 1..8.
REQ-002 Parameter SW, default 4: sensor and threshold width in bits, 2..8.
REQ-003 Parameter MIN_ON, default 1000: minimum actuator on-dwell in enabled cycles, >=1.
REQ-004 Parameter MIN_OFF, default 1000: minimum actuator off-dwell in enabled cycles, >=1.
REQ-005 Parameter MAX_ON, default 1_000_000: continuous-on limit in enabled cycles before stuck fault; must exceed MIN_ON.
REQ-006 Parameter HB_DIV, default 12_500_000: heartbeat half-period in enabled cycles, >=2.
REQ-007 clk  in  1  single system clock; all state on rising edge.
REQ-008 rst  in  1  asynchronous, active-high reset.
REQ-009 ena  in  1  clock-enable; when low, all state holds.
REQ-010 sensor  in  N_CH*SW  channel i reading at [i*SW +: SW], unsigned.
REQ-011 thr_lo  in  N_CH*SW  per-channel lower hysteresis threshold.
REQ-012 thr_hi  in  N_CH*SW  per-channel upper hysteresis threshold.
REQ-013 polarity  in  N_CH  0 = actuator raises quantity (heater/pump/light), 1 = lowers it (cooler/dehumidifier).
REQ-014 override  in  1  level; forces all actuators off.
REQ-015 fault_clr  in  1  single-cycle pulse; clears latched faults.
REQ-016 act  out  N_CH  registered actuator drives.
REQ-017 fault  out  N_CH  registered per-channel latched fault.
REQ-018 cfg_err  out  N_CH  registered; thr_lo > thr_hi on that channel.
REQ-019 fault_any  out  1  registered OR of fault and cfg_err.
REQ-020 heartbeat  out  1  registered square wave.

Function
REQ-021 Demand register per channel, updated every enabled cycle: polarity 0 sets when sensor < thr_lo and clears when sensor > thr_hi; polarity 1 sets when sensor > thr_hi and clears when sensor < thr_lo; otherwise holds; all compares unsigned SW-bit.
REQ-022 cfg_err[i] registers (thr_lo > thr_hi) each enabled cycle; while it is set, demand[i] is forced to 0.
REQ-023 Per-channel FSM states OFF, ON, FAULT; act[i] = (state == ON), which is a register decode.
REQ-024 Dwell counter per channel resets to 0 on every state change, else increments, saturating at max(MIN_ON, MIN_OFF, MAX_ON); width is clog2 of that value plus 1.
REQ-025 OFF -> ON when demand && dwell >= MIN_OFF-1 && !override && !cfg_err.
REQ-026 ON -> OFF when override (immediate, ignores MIN_ON), or when !demand && dwell >= MIN_ON-1.
REQ-027 ON -> FAULT when dwell == MAX_ON-1 and no ON -> OFF condition holds; fault[i] is set in the same edge.
REQ-028 FAULT holds act low and exits to OFF (dwell 0, fault[i] cleared) only on fault_clr; fault_clr in OFF or ON has no effect.
REQ-029 Latency: a sensor change reaches act 2 enabled cycles later (demand register, then FSM), provided the dwell condition is already met.
REQ-030 Simultaneous events in ON: override takes priority over the MAX_ON fault.
REQ-031 Heartbeat: counter 0..HB_DIV-1; toggles heartbeat and wraps to 0 at HB_DIV-1.
REQ-032 ena low freezes demand, FSMs, counters and heartbeat; outputs hold.

Reset
REQ-033 While rst is high: act=0, fault=0, cfg_err=0, fault_any=0, heartbeat=0, demand=0, FSM=OFF, all counters=0.
REQ-034 Reset asserted mid-dwell or in FAULT takes effect asynchronously; after release, MIN_OFF restarts from 0.

Structure
REQ-035 Package ag_ctrl_pkg holds the state enum (OFF/ON/FAULT) and the polarity constants RAISE=0, LOWER=1.
REQ-036 One sub-module, ag_channel_fsm (demand, dwell counter, FSM for one channel), is instantiated N_CH times by a generate loop; heartbeat and fault_any live in the top.

Verification (N_CH=4, SW=4, MIN_ON=4, MIN_OFF=4, MAX_ON=16, HB_DIV=8)
REQ-037 ch0 pol=0, lo=5, hi=10; sensor 3 held after reset -> act[0] rises at cycle 4 (MIN_OFF); sensor 7 -> act stays 1; sensor 12 -> act[0] falls 2 cycles later once dwell>=4.
REQ-038 ch2 pol=1, lo=5, hi=10; sensor 12 for 2 cycles then 7 -> demand latches and act[2] holds high for at least 4 cycles.
REQ-039 ch1 demand held for 20 cycles -> act[1] drops and fault[1]=fault_any=1 after 16 on-cycles; fault_clr pulse -> fault clears and act[1] re-rises after 4 cycles.
REQ-040 ch3 lo=9, hi=4 -> cfg_err[3]=1, fault_any=1, act[3] stays 0.
REQ-041 All channels on, override=1 -> all act=0 on the next edge; ena=0 for 10 cycles -> heartbeat and act frozen.
REQ-042 rst pulsed mid-ON -> all outputs 0 immediately; the heartbeat period is 16 cycles after release.
